// File: rtl/tengbe_rx_snap_capture_if.sv
// ---------------------------------------------------------------------------
// tengbe_rx_snap_capture_if
// BRAM write bus between the RX snapshot capture controller and the
// snapshot BRAM.
//   bram_addr : BRAM write address (ADDR_WIDTH)
//   bram_data : BRAM write data    (DATA_WIDTH)
//   bram_we   : BRAM write enable
// modport master : capture controller (drives the bus)
// modport slave  : BRAM side (observes the bus)
// ---------------------------------------------------------------------------
interface tengbe_rx_snap_capture_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [DATA_WIDTH-1:0] bram_data;
  logic                  bram_we;

  modport master (output bram_addr, output bram_data, output bram_we);
  modport slave  (input  bram_addr, input  bram_data, input  bram_we);
endinterface

// File: rtl/tengbe_rx_snap_capture.sv
// ---------------------------------------------------------------------------
// tengbe_rx_snap_capture
// Capture controller for the 10GbE receive snapshot. On a rising edge of
// ctrl[0] it arms, waits for the (optional) trigger, then writes one window
// of 2^ADDR_WIDTH qualified RX words into the snapshot BRAM and reports
// progress through a status word.
// Ports:
//   user_clk  : sole clock
//   user_rst  : asynchronous active-high reset
//   ctrl      : [0] arm (edge), [1] trig_en, [2] valid_qual
//   rx_data   : RX data word
//   rx_valid  : RX data-valid qualifier
//   trig      : external trigger level
//   bram      : BRAM write bus (master modport), all outputs registered
//   status    : [31] done, [30] busy, [ADDR_WIDTH:0] words written
// ---------------------------------------------------------------------------
module tengbe_rx_snap_capture #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 64
) (
  input  logic                            user_clk,
  input  logic                            user_rst,
  input  logic [31:0]                     ctrl,
  input  logic [DATA_WIDTH-1:0]           rx_data,
  input  logic                            rx_valid,
  input  logic                            trig,
  tengbe_rx_snap_capture_if.master        bram,
  output logic [31:0]                     status
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Address of the final word in the window; writing it ends the capture.
  localparam logic [ADDR_WIDTH:0] LAST_ADDR = {1'b0, {ADDR_WIDTH{1'b1}}};

  state_t                  state_reg, state_next;
  logic                    ctrl_q_reg;
  logic [ADDR_WIDTH:0]     count_reg, count_next;
  logic [ADDR_WIDTH-1:0]   bram_addr_reg;
  logic [DATA_WIDTH-1:0]   bram_data_reg;
  logic                    bram_we_reg;
  logic [31:0]             status_reg, status_next;

  logic arm_pulse;
  logic qual;
  logic start;
  logic accept;

  // Only bits [2:0] of the control word carry meaning.
  logic unused_ctrl_bits;
  assign unused_ctrl_bits = ^ctrl[31:3];

  assign arm_pulse = ctrl[0] & ~ctrl_q_reg;
  assign qual      = rx_valid | ~ctrl[2];
  assign start     = ctrl[1] ? trig : 1'b1;

  // Next-state / sample-accept logic. arm_pulse outranks everything so a
  // re-arm aborts a capture in progress without writing on that cycle.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    accept     = 1'b0;
    if (arm_pulse) begin
      state_next = ARMED;
      count_next = '0;
    end else begin
      unique case (state_reg)
        IDLE: ;
        ARMED: begin
          // An unqualified trigger is dropped, not remembered.
          if (start && qual) begin
            accept     = 1'b1;
            count_next = count_reg + 1'b1;
            state_next = CAPTURE;
          end
        end
        CAPTURE: begin
          if (qual) begin
            accept     = 1'b1;
            count_next = count_reg + 1'b1;
            if (count_reg == LAST_ADDR) state_next = DONE;
          end
        end
        DONE: ;
        default: state_next = IDLE;
      endcase
    end
  end

  // Status mirrors the current state/count, so it lags them by one cycle.
  always_comb begin
    status_next                 = '0;
    status_next[31]             = (state_reg == DONE);
    status_next[30]             = (state_reg == ARMED) || (state_reg == CAPTURE);
    status_next[ADDR_WIDTH:0]   = count_reg;
  end

  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      state_reg     <= IDLE;
      ctrl_q_reg    <= 1'b0;
      count_reg     <= '0;
      bram_addr_reg <= '0;
      bram_data_reg <= '0;
      bram_we_reg   <= 1'b0;
      status_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      ctrl_q_reg  <= ctrl[0];
      count_reg   <= count_next;
      bram_we_reg <= accept;
      status_reg  <= status_next;
      // Address/data hold their last values between writes.
      if (accept) begin
        bram_addr_reg <= count_reg[ADDR_WIDTH-1:0];
        bram_data_reg <= rx_data;
      end
    end
  end

  assign bram.bram_addr = bram_addr_reg;
  assign bram.bram_data = bram_data_reg;
  assign bram.bram_we   = bram_we_reg;
  assign status         = status_reg;

endmodule

// File: tb/tb_tengbe_rx_snap_capture.sv
module tb_tengbe_rx_snap_capture;
  localparam int AW = 4;
  localparam int DW = 64;

  logic          user_clk = 1'b0;
  logic          user_rst = 1'b1;
  logic [31:0]   ctrl     = '0;
  logic [DW-1:0] rx_data  = '0;
  logic          rx_valid = 1'b0;
  logic          trig     = 1'b0;
  logic [31:0]   status;

  int checks = 0;
  int errors = 0;

  tengbe_rx_snap_capture_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bram_if ();

  tengbe_rx_snap_capture #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .user_clk (user_clk),
    .user_rst (user_rst),
    .ctrl     (ctrl),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .trig     (trig),
    .bram     (bram_if.master),
    .status   (status)
  );

  always #5 user_clk = ~user_clk;

  task automatic tick();
    @(posedge user_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_write(input string tag, input int addr, input logic [63:0] data);
    check({tag, "_we"}, 64'(bram_if.bram_we), 64'd1);
    check({tag, "_addr"}, 64'(bram_if.bram_addr), 64'(addr));
    check({tag, "_data"}, bram_if.bram_data, data);
  endtask

  initial begin
    // ---------------- reset ----------------
    tick(); tick();
    user_rst = 1'b0;
    tick();
    check("rst_status", 64'(status), 64'h0);
    check("rst_we", 64'(bram_if.bram_we), 64'd0);
    check("rst_addr", 64'(bram_if.bram_addr), 64'd0);

    // ---------------- immediate capture ----------------
    ctrl = 32'h1; rx_data = 64'd100;
    tick();                                   // arm cycle: no write
    check("imm_arm_we", 64'(bram_if.bram_we), 64'd0);
    for (int i = 0; i < 16; i++) begin
      rx_data = 64'(200 + i);
      tick();
      check_write($sformatf("imm_w%0d", i), i, 64'(200 + i));
      if (i == 0) check("imm_busy", 64'(status), 64'h4000_0000);
    end
    check("imm_status_last", 64'(status), 64'h4000_000F);
    rx_data = 64'd999;
    tick();
    check("imm_done_status", 64'(status), 64'h8000_0010);
    check("imm_done_we", 64'(bram_if.bram_we), 64'd0);
    // ctrl[0] held high: must not re-arm
    for (int i = 0; i < 3; i++) begin
      tick();
      check("imm_hold_we", 64'(bram_if.bram_we), 64'd0);
    end
    check("imm_hold_addr", 64'(bram_if.bram_addr), 64'd15);
    check("imm_hold_data", bram_if.bram_data, 64'd215);
    check("imm_hold_status", 64'(status), 64'h8000_0010);

    // ---------------- triggered capture + re-arm abort ----------------
    ctrl = 32'h0; tick();
    ctrl = 32'h3; tick();                     // arm
    for (int i = 0; i < 5; i++) begin
      rx_data = 64'(500 + i);
      tick();
      check("trg_wait_we", 64'(bram_if.bram_we), 64'd0);
    end
    check("trg_wait_status", 64'(status), 64'h4000_0000);
    trig = 1'b1; rx_data = 64'hABC;
    tick();
    check_write("trg_first", 0, 64'hABC);
    trig = 1'b0; rx_data = 64'hABD;
    tick();
    check_write("trg_second", 1, 64'hABD);
    ctrl = 32'h0; rx_data = 64'hABE;          // still capturing
    tick();
    check_write("trg_third", 2, 64'hABE);
    ctrl = 32'h1; rx_data = 64'hBAD;          // re-arm: aborts, no write
    tick();
    check("abort_we", 64'(bram_if.bram_we), 64'd0);
    check("abort_status", 64'(status), 64'h4000_0003);
    for (int i = 0; i < 7; i++) begin
      rx_data = 64'(700 + i);
      tick();
      check_write($sformatf("rearm_w%0d", i), i, 64'(700 + i));
      if (i == 0) check("rearm_status0", 64'(status), 64'h4000_0000);
      if (i == 1) check("rearm_status1", 64'(status), 64'h4000_0001);
    end

    // ---------------- reset mid-capture (asynchronous) ----------------
    #2;
    user_rst = 1'b1;
    #1;
    check("arst_we", 64'(bram_if.bram_we), 64'd0);
    check("arst_status", 64'(status), 64'h0);
    check("arst_addr", 64'(bram_if.bram_addr), 64'd0);
    ctrl = 32'h0;
    tick();
    #2 user_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_we", 64'(bram_if.bram_we), 64'd0);
      check("post_rst_status", 64'(status), 64'h0);
    end

    // ---------------- valid qualification ----------------
    ctrl = 32'h5; rx_valid = 1'b0;
    tick();                                   // arm
    check("vq_arm_we", 64'(bram_if.bram_we), 64'd0);
    for (int k = 0; k < 32; k++) begin
      rx_valid = (k % 2 == 0);
      rx_data  = 64'(300 + k);
      tick();
      if (k % 2 == 0) check_write($sformatf("vq_k%0d", k), k / 2, 64'(300 + k));
      else            check($sformatf("vq_k%0d_we", k), 64'(bram_if.bram_we), 64'd0);
    end
    check("vq_done_status", 64'(status), 64'h8000_0010);

    // ---------------- trigger without valid ----------------
    ctrl = 32'h0; rx_valid = 1'b0; tick();
    ctrl = 32'h7; tick();                     // arm
    trig = 1'b1; rx_valid = 1'b0; rx_data = 64'h444;
    tick();
    check("tnv_we0", 64'(bram_if.bram_we), 64'd0);
    trig = 1'b0; rx_valid = 1'b1; rx_data = 64'h445;
    tick();
    check("tnv_we1", 64'(bram_if.bram_we), 64'd0);
    check("tnv_status", 64'(status), 64'h4000_0000);
    trig = 1'b1; rx_valid = 1'b1; rx_data = 64'h555;
    tick();
    check_write("tnv_first", 0, 64'h555);
    trig = 1'b0; rx_data = 64'h556;
    tick();
    check_write("tnv_second", 1, 64'h556);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
